// File: rtl/uart_to_between.sv
// UART 8N1 receiver -> 4-entry FIFO -> 4-phase parallel link, with a running CRC-8 per packet.
// Build option: define CRC_APPEND_EN to send the CRC byte after every PKT_LEN data bytes.
`timescale 1ns/1ps
module uart_to_between #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PKT_LEN      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       trecieve,
  output logic [7:0] tdata,
  output logic       tsent,
  output logic       frame_err,
  output logic       overflow,
  output logic [7:0] crc
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]       PKT_LAST  = 8'(PKT_LEN);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_RELEASE}       tx_state_t;

  // CRC-8, polynomial 0x07, MSB first, one byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             push;

  logic [7:0]       buf_mem [4];
  logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, do_push, pop;

  tx_state_t        tx_state_q, tx_state_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tsent_q, tsent_d;
  logic             is_crc_q, is_crc_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic             crc_due;

  // Receiver: start-bit detect, mid-bit sampling, stop-bit validation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rx_state_d  = rx_state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    push        = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = R_START;
          bit_cnt_d  = '0;
        end
      end
      R_START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d  = '0;
          rx_state_d = R_IDLE;
          if (rx_s2_q) push        = 1'b1;
          else         frame_err_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // A push into a full FIFO survives only when the same cycle frees a slot.
  always_comb begin
    full       = (count_q == 3'd4);
    empty      = (count_q == 3'd0);
    do_push    = push && (!full || pop);
    overflow_d = overflow_q | (push && full && !pop);
    wr_ptr_d   = do_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d   = pop     ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d    = count_q;
    if (do_push && !pop)      count_d = count_q + 3'd1;
    else if (!do_push && pop) count_d = count_q - 3'd1;
  end

  // Transmit side: 4-phase handshake, CRC folded in once the receiver acknowledges.
  always_comb begin
    tx_state_d = tx_state_q;
    tdata_d    = tdata_q;
    is_crc_d   = is_crc_q;
    crc_d      = crc_q;
    byte_cnt_d = byte_cnt_q;
    pop        = 1'b0;
`ifdef CRC_APPEND_EN
    crc_due    = (byte_cnt_q == PKT_LAST);
`else
    crc_due    = 1'b0;
`endif
    unique case (tx_state_q)
      T_IDLE: begin
        if (crc_due) begin
          tdata_d    = crc_q;
          is_crc_d   = 1'b1;
          tx_state_d = T_SEND;
        end else if (!empty) begin
          tdata_d    = buf_mem[rd_ptr_q];
          pop        = 1'b1;
          is_crc_d   = 1'b0;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (trecieve) begin
          tx_state_d = T_RELEASE;
          if (!is_crc_q) begin
            crc_d      = crc8_byte(crc_q, tdata_q);
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      T_RELEASE: begin
        if (!trecieve) begin
          tx_state_d = T_IDLE;
`ifdef CRC_APPEND_EN
          if (is_crc_q) begin
`else
          if (byte_cnt_q == PKT_LAST) begin
`endif
            crc_d      = 8'h00;
            byte_cnt_d = 8'd0;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
    tsent_d = (tx_state_d == T_SEND);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= R_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      tx_state_q  <= T_IDLE;
      tdata_q     <= 8'h00;
      tsent_q     <= 1'b0;
      is_crc_q    <= 1'b0;
      crc_q       <= 8'h00;
      byte_cnt_q  <= 8'd0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      tx_state_q  <= tx_state_d;
      tdata_q     <= tdata_d;
      tsent_q     <= tsent_d;
      is_crc_q    <= is_crc_d;
      crc_q       <= crc_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) buf_mem[wr_ptr_q] <= shift_q;
  end

  assign tdata     = tdata_q;
  assign tsent     = tsent_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign crc       = crc_q;

endmodule

// File: tb/tb_uart_to_between.sv
// Self-checking bench for uart_to_between: frame tables, handshake corner cases and random
// traffic compared against a packet-level model of the link stream (honours CRC_APPEND_EN).
`timescale 1ns/1ps
module tb_uart_to_between;

  localparam int CPB = 16;
  localparam int PKT = 4;

  logic       clk = 1'b0;
  logic       reset, rx, trecieve;
  logic [7:0] tdata, crc;
  logic       tsent, frame_err, overflow;

  uart_to_between #(.CLKS_PER_BIT(CPB), .PKT_LEN(PKT)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .trecieve  (trecieve),
    .tdata     (tdata),
    .tsent     (tsent),
    .frame_err (frame_err),
    .overflow  (overflow),
    .crc       (crc)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int resp_mode = 1;   // 0: hold ack low, 1: immediate ack, 2: random-latency ack

  logic [7:0] cap_q[$], cap_crc_q[$], exp_link[$], exp_crc[$];
  logic [7:0] m_crc;
  int         m_cnt;
  logic       mon_prev;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
  endtask

  // Remainder of (c^d)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = {c ^ d, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    end
    return r[7:0];
  endfunction

  task automatic model_reset();
    m_crc = 8'h00;
    m_cnt = 0;
    exp_link.delete();
    exp_crc.delete();
  endtask

  // Each accepted data byte goes on the link; every PKT bytes the packet closes.
  task automatic model_data(input logic [7:0] d);
    exp_link.push_back(d);
    m_crc = crc_ref(m_crc, d);
    exp_crc.push_back(m_crc);
    m_cnt++;
    if (m_cnt == PKT) begin
`ifdef CRC_APPEND_EN
      exp_link.push_back(m_crc);
      exp_crc.push_back(m_crc);
`endif
      m_crc = 8'h00;
      m_cnt = 0;
    end
  endtask

  task automatic clear_capture();
    cap_q.delete();
    cap_crc_q.delete();
  endtask

  task automatic compare_stream(input string name);
    check({name, " link count"}, cap_q.size(), exp_link.size());
    check({name, " crc count"}, cap_crc_q.size(), exp_crc.size());
    for (int i = 0; i < exp_link.size() && i < cap_q.size(); i++) begin
      check($sformatf("%s byte%0d", name, i), cap_q[i], exp_link[i]);
      if (i < cap_crc_q.size() && i < exp_crc.size())
        check($sformatf("%s crc%0d", name, i), cap_crc_q[i], exp_crc[i]);
    end
    clear_capture();
    exp_link.delete();
    exp_crc.delete();
  endtask

  // Link monitor: tdata at tsent rise, crc at tsent fall.
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tsent === 1'b1 && !mon_prev) cap_q.push_back(tdata);
      if (tsent !== 1'b1 && mon_prev)  cap_crc_q.push_back(crc);
      mon_prev = (tsent === 1'b1);
    end
  end

  // Link responder.
  initial begin
    trecieve = 1'b0;
    forever begin
      @(negedge clk);
      case (resp_mode)
        0:       trecieve = 1'b0;
        1:       trecieve = tsent;
        default: if (tsent !== trecieve && $urandom_range(0, 2) == 0) trecieve = tsent;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    vecs[0] = '{8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b0};
    vecs[4] = '{8'h7E, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 1'b0, 1'b1};

    rx    = 1'b1;
    reset = 1'b1;
    model_reset();
    tick(3);
    check("reset tsent", tsent, 1'b0);
    check("reset tdata", tdata, 8'h00);
    check("reset crc", crc, 8'h00);
    check("reset frame_err", frame_err, 1'b0);
    check("reset overflow", overflow, 1'b0);
    reset = 1'b0;
    tick(2);

    // Packet 00,00,00,01 with immediate ack.
    resp_mode = 1;
    for (int i = 0; i < 4; i++) begin
      b = (i == 3) ? 8'h01 : 8'h00;
      send_frame(b, 1'b1);
      model_data(b);
      tick(CPB);
    end
    compare_stream("pkt");
    check("crc after packet", crc, 8'h00);

    // Frame table, ending with a bad stop bit.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].stop) model_data(vecs[i].data);
      tick(CPB);
      check($sformatf("table%0d frame_err", i), frame_err, vecs[i].exp_err);
      check($sformatf("table%0d sent", i), cap_q.size(), exp_link.size());
    end
    check("bad frame tsent", tsent, 1'b0);
    compare_stream("table");

    // Short low glitch on rx must be rejected.
    rx = 1'b0;
    tick(CPB / 4);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch no byte", cap_q.size(), 0);
    check("glitch tsent", tsent, 1'b0);

    // Overflow: ack held while six bytes arrive.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_reset();
    tick(1);
    clear_capture();
    check("reset clears frame_err", frame_err, 1'b0);
    resp_mode = 0;
    for (int i = 0; i < 6; i++) begin
      b = 8'hA0 + 8'(i);
      send_frame(b, 1'b1);
      if (i < 5) model_data(b);
    end
    tick(CPB);
    check("ovf tsent held", tsent, 1'b1);
    check("ovf tdata held", tdata, 8'hA0);
    check("ovf flag", overflow, 1'b1);
    resp_mode = 1;
    tick(8 * CPB);
    compare_stream("ovf");

    // Reset in the middle of a handshake, with a byte still buffered.
    resp_mode = 0;
    send_frame(8'h99, 1'b1);
    send_frame(8'h77, 1'b1);
    tick(CPB);
    check("pre-reset tsent", tsent, 1'b1);
    check("pre-reset tdata", tdata, 8'h99);
    reset = 1'b1;
    tick(1);
    check("midreset tsent", tsent, 1'b0);
    check("midreset tdata", tdata, 8'h00);
    check("midreset crc", crc, 8'h00);
    check("midreset overflow", overflow, 1'b0);
    check("midreset frame_err", frame_err, 1'b0);
    reset = 1'b0;
    model_reset();
    tick(2);
    clear_capture();
    resp_mode = 1;
    tick(4 * CPB);
    check("post-reset buffer empty", cap_q.size(), 0);
    send_frame(8'h3C, 1'b1);
    model_data(8'h3C);
    tick(CPB);
    compare_stream("after reset");

    // Random traffic with random ack latency.
    resp_mode = 2;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_data(b);
      tick($urandom_range(0, CPB));
    end
    tick(8 * CPB);
    compare_stream("rand");
    check("rand crc idle", crc, m_crc);
    check("rand no overflow", overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_to_between.md
UART_TO_BETWEEN -- requirements
Module: uart_to_between

Interface
- REQ-001: The module SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per UART bit (even, >=4).
- REQ-002: The module SHALL have parameter PKT_LEN, default 4, giving data bytes per packet (1..255).
- REQ-003: The module SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
- REQ-004: The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005: The module SHALL have port rx, input, 1 bit: UART serial in (8N1, LSB first, idle high, asynchronous to clk).
- REQ-006: The module SHALL have port trecieve, input, 1 bit: acknowledge from the parallel-link receiver.
- REQ-007: The module SHALL have port tdata, output, 8 bits: parallel-link data, driving t7..t0.
- REQ-008: The module SHALL have port tsent, output, 1 bit: parallel-link data-valid strobe.
- REQ-009: The module SHALL have port frame_err, output, 1 bit: sticky flag, stop bit sampled low.
- REQ-010: The module SHALL have port overflow, output, 1 bit: sticky flag, byte dropped because the buffer was full.
- REQ-011: The module SHALL have port crc, output, 8 bits: running CRC-8 of the current packet.

Function
- REQ-012: rx SHALL pass through a 2-flop synchronizer; both flops take 1 on reset.
- REQ-013: RX FSM states SHALL be R_IDLE, R_START, R_DATA, R_STOP; a synchronized high-to-low transition in R_IDLE SHALL enter R_START.
- REQ-014: R_START SHALL wait CLKS_PER_BIT/2 cycles, then enter R_DATA if rx is 0; otherwise it SHALL return to R_IDLE (glitch reject).
- REQ-015: R_DATA SHALL sample rx every CLKS_PER_BIT cycles, 8 samples, LSB first, then enter R_STOP.
- REQ-016: R_STOP SHALL sample rx after CLKS_PER_BIT cycles; on 1 the byte SHALL be pushed into the buffer, on 0 frame_err SHALL set and the byte SHALL be discarded; the FSM SHALL then return to R_IDLE.
- REQ-017: The buffer SHALL be a 4-entry circular FIFO with 2-bit wrapping pointers and a 3-bit count.
- REQ-018: A push to a full buffer SHALL drop the byte and set overflow, unless a pop occurs in the same cycle, in which case both SHALL proceed.
- REQ-019: TX FSM states SHALL be T_IDLE, T_SEND, T_RELEASE.
- REQ-020: In T_IDLE with the buffer non-empty (or a CRC byte pending), the FSM SHALL load tdata, pop the buffer if sending data, and enter T_SEND.
- REQ-021: tsent SHALL be 1 exactly while in T_SEND.
- REQ-022: T_SEND SHALL hold until trecieve==1, then enter T_RELEASE.
- REQ-023: T_RELEASE SHALL hold until trecieve==0, then return to T_IDLE; this is a 4-phase handshake.
- REQ-024: tdata SHALL stay stable from T_SEND entry until T_RELEASE exit.
- REQ-025: Latency: a byte pushed into an empty buffer at edge N, with TX in T_IDLE, SHALL have tsent high after edge N+1.
- REQ-026: CRC SHALL be CRC-8, polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
- REQ-027: crc SHALL be updated with each data byte on T_SEND to T_RELEASE.
- REQ-028: A byte counter SHALL count data bytes sent, 0..PKT_LEN.
- REQ-029: When the counter reaches PKT_LEN (see Configuration), crc SHALL be the next transfer, with priority over the buffer.
- REQ-030: When the CRC transfer completes T_RELEASE, crc SHALL clear to 0x00 and the counter SHALL clear to 0.
- REQ-031: RX SHALL continue receiving and buffering during all TX states.

Reset
- REQ-032: On reset, both FSMs SHALL go idle and the buffer SHALL empty.
- REQ-033: On reset, tdata, crc and the counter SHALL be 0x00/0, and tsent, frame_err and overflow SHALL be 0, all visible after the reset edge.
- REQ-034: Reset mid-handshake SHALL drop tsent on the next edge, with no resume.

Configuration
- REQ-035: The macro CRC_APPEND_EN SHALL control CRC appending.
- REQ-036: With CRC_APPEND_EN defined, behaviour SHALL be as REQ-029/030: every PKT_LEN data bytes are followed by one CRC byte.
- REQ-037: Without CRC_APPEND_EN, no CRC byte SHALL be sent, the counter wraps at PKT_LEN, and crc still computes and clears on each wrap.

Verification
- REQ-038: UART bytes 0x00,0x00,0x00,0x01 with an immediate-ack responder and CRC_APPEND_EN -> link carries 00,00,00,01,07; crc returns to 0x00.
- REQ-039: Same stimulus without CRC_APPEND_EN -> link carries 00,00,00,01 only; crc reads 0x07 before wrap, then 0x00.
- REQ-040: Responder holds trecieve low while 6 bytes A0..A5 arrive -> A0 held on tdata with tsent=1, A1..A4 buffered, A5 dropped, overflow=1, then A0..A4 delivered in order.
- REQ-041: rx low pulse of CLKS_PER_BIT/4 cycles -> no byte pushed, tsent stays 0; a frame 0x55 with low stop bit -> frame_err=1, nothing sent.
- REQ-042: Reset asserted while tsent=1 -> next edge tsent=0, tdata=0x00, buffer empty, flags 0; a subsequent byte 0x3C is delivered normally.
